// File: rtl/zmod_link_pkg.sv
// ============================================================================
// zmod_link_pkg : shared link-checker types, defaults and saturating increment
// Rev 1.0
// ============================================================================
`default_nettype none

package zmod_link_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // Saturating increment for any counter up to 64 bits wide; callers cast the result back down.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_word_aligner.sv
// ============================================================================
// rx_word_aligner : previous-word register and barrel shift selecting the
//                   W-bit window at the current bit offset
// Rev 1.0
// ============================================================================
`default_nettype none

module rx_word_aligner
    import zmod_link_pkg::*;
#(
    parameter int W  = DEFAULT_W,
    parameter int OW = $clog2(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  din,
    input  logic          din_valid,
    input  logic [OW-1:0] offset,
    input  logic          flush,
    output logic [W-1:0]  aligned,
    output logic          aligned_valid
);

    logic [W-1:0]   prev;
    logic           prev_loaded;
    logic [2*W-1:0] window;

    assign window = {din, prev} >> offset;

    // flush marks the edge where the offset changes: the word shifted with the
    // old offset is dropped, and prev only counts once reloaded at/after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev          <= '0;
            prev_loaded   <= 1'b0;
            aligned       <= '0;
            aligned_valid <= 1'b0;
        end else begin
            aligned_valid <= 1'b0;
            if (din_valid) begin
                prev          <= din;
                aligned       <= window[W-1:0];
                aligned_valid <= prev_loaded && !flush;
                prev_loaded   <= 1'b1;
            end else if (flush) begin
                prev_loaded <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rx_pattern_checker.sv
// ============================================================================
// rx_pattern_checker : hunts for the bit offset carrying an incrementing
//                      counter, locks, then flags and counts mismatches.
//                      RX_CHECKER_STATS_EN enables err_count / word_count.
// Rev 1.0
// ============================================================================
`default_nettype none

module rx_pattern_checker
    import zmod_link_pkg::*;
#(
    parameter int W           = DEFAULT_W,
    parameter int LOCK_COUNT  = 16,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [W-1:0]         din,
    input  logic                 din_valid,
    output logic                 locked,
    output logic                 error,
    output logic [$clog2(W)-1:0] offset,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     word_count
);

    localparam int OW = $clog2(W);

    chk_state_t    state;
    logic [W-1:0]  aligned;
    logic          aligned_valid;
    logic [W-1:0]  expected;
    logic          seeded;
    logic [7:0]    good_cnt;
    logic [7:0]    bad_run;
    logic          match;
    logic          flush;
    logic [OW-1:0] offset_next;

    assign match       = (aligned == expected);
    assign flush       = aligned_valid && (state == HUNT) && seeded && !match;
    assign offset_next = (offset == OW'(W - 1)) ? '0 : offset + 1'b1;

    rx_word_aligner #(
        .W  (W),
        .OW (OW)
    ) u_aligner (
        .clk           (clk),
        .reset         (reset),
        .din           (din),
        .din_valid     (din_valid),
        .offset        (offset),
        .flush         (flush),
        .aligned       (aligned),
        .aligned_valid (aligned_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HUNT;
            offset   <= '0;
            expected <= '0;
            seeded   <= 1'b0;
            good_cnt <= '0;
            bad_run  <= '0;
            error    <= 1'b0;
            locked   <= 1'b0;
        end else begin
            error <= 1'b0;
            if (aligned_valid) begin
                case (state)
                    HUNT: begin
                        if (!seeded) begin
                            seeded   <= 1'b1;
                            expected <= aligned + 1'b1;
                        end else if (match) begin
                            expected <= aligned + 1'b1;
                            if (good_cnt + 8'd1 == 8'(LOCK_COUNT)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                good_cnt <= '0;
                                bad_run  <= '0;
                            end else begin
                                good_cnt <= good_cnt + 8'd1;
                            end
                        end else begin
                            good_cnt <= '0;
                            offset   <= offset_next;
                            seeded   <= 1'b0;
                        end
                    end
                    LOCKED: begin
                        // Free-running expectation: one corrupted word costs exactly one error.
                        expected <= expected + 1'b1;
                        if (match) begin
                            bad_run <= '0;
                        end else begin
                            error <= 1'b1;
                            if (bad_run + 8'd1 == 8'(LOSS_THRESH)) begin
                                state   <= HUNT;
                                locked  <= 1'b0;
                                seeded  <= 1'b0;
                                bad_run <= '0;
                            end else begin
                                bad_run <= bad_run + 8'd1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

`ifdef RX_CHECKER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count  <= '0;
            word_count <= '0;
        end else if (aligned_valid && (state == LOCKED)) begin
            word_count <= CNT_W'(sat_inc(64'(word_count), CNT_W));
            if (!match) begin
                err_count <= CNT_W'(sat_inc(64'(err_count), CNT_W));
            end
        end
    end
`else
    assign err_count  = '0;
    assign word_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_pattern_checker.sv
// ============================================================================
// tb_rx_pattern_checker : self-checking bench for rx_pattern_checker
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rx_pattern_checker;

    localparam int W           = 8;
    localparam int LOCK_COUNT  = 16;
    localparam int LOSS_THRESH = 4;
    localparam int CNT_W       = 32;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [W-1:0]     din;
    logic             din_valid;
    logic             locked;
    logic             error;
    logic [2:0]       offset;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] word_count;

    rx_pattern_checker #(
        .W           (W),
        .LOCK_COUNT  (LOCK_COUNT),
        .LOSS_THRESH (LOSS_THRESH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .locked     (locked),
        .error      (error),
        .offset     (offset),
        .err_count  (err_count),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        err;
        logic        lk;
        logic [2:0]  off;
        logic [31:0] ec;
        logic [31:0] wc;
    } exp_t;

    typedef struct {
        bit         rst;
        logic [7:0] start;
        int         n;
        int         shift;
        int         gap;
        bit         exp_lk;
        logic [2:0] exp_off;
    } row_t;

    exp_t q[$];
    exp_t hold;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   err_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state (word-level, follows the stream bit alignment)
    logic [7:0] m_prev, m_exp, last_c;
    bit         m_prev_ok, m_seeded, m_locked;
    int         m_off, m_good, m_bad;
    longint     m_ec, m_wc;

    task automatic model_reset();
        m_prev = '0; m_exp = '0; m_prev_ok = 0; m_seeded = 0; m_locked = 0;
        m_off = 0; m_good = 0; m_bad = 0; m_ec = 0; m_wc = 0;
        q.delete();
        hold = '{due: 0, err: 1'b0, lk: 1'b0, off: 3'd0, ec: 32'd0, wc: 32'd0};
    endtask

    task automatic model_word(input logic [7:0] d);
        logic [15:0] cat;
        logic [7:0]  al;
        bit          ok;
        exp_t        e;
        cat = {d, m_prev} >> m_off;
        al  = cat[7:0];
        ok  = m_prev_ok;
        m_prev = d;
        m_prev_ok = 1;
        e.err = 1'b0;
        if (ok) begin
            if (!m_locked) begin
                if (!m_seeded) begin
                    m_seeded = 1;
                    m_exp = al + 8'd1;
                end else if (al == m_exp) begin
                    m_exp = al + 8'd1;
                    m_good++;
                    if (m_good == LOCK_COUNT) begin
                        m_locked = 1; m_good = 0; m_bad = 0;
                    end
                end else begin
                    m_good = 0; m_off = (m_off + 1) % W; m_seeded = 0; m_prev_ok = 0;
                end
            end else begin
                if (m_wc < CNT_MAX) m_wc++;
                if (al != m_exp) begin
                    e.err = 1'b1;
                    if (m_ec < CNT_MAX) m_ec++;
                    m_bad++;
                    if (m_bad == LOSS_THRESH) begin
                        m_locked = 0; m_seeded = 0; m_bad = 0;
                    end
                end else begin
                    m_bad = 0;
                end
                m_exp = m_exp + 8'd1;
            end
        end
        e.due = cyc + 2;
        e.lk  = m_locked;
        e.off = 3'(m_off);
`ifdef RX_CHECKER_STATS_EN
        e.ec = 32'(m_ec);
        e.wc = 32'(m_wc);
`else
        e.ec = 32'd0;
        e.wc = 32'd0;
`endif
        q.push_back(e);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Called on the falling edge, away from the active edge.
    task automatic check_cycle();
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            hold = e;
        end else begin
            e = hold;
            e.err = 1'b0;
        end
        cmp("error", 32'(error), 32'(e.err));
        cmp("locked", 32'(locked), 32'(e.lk));
        cmp("offset", 32'(offset), 32'(e.off));
        cmp("err_count", err_count, e.ec);
        cmp("word_count", word_count, e.wc);
        if (error === 1'b1) err_pulses++;
    endtask

    task automatic drive(input logic [7:0] d, input logic v);
        din = d;
        din_valid = v;
        if (v) model_word(d);
        @(posedge clk);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic do_reset(input logic [7:0] start);
        reset = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        last_c = start - 8'd1;
        check_cycle();
    endtask

    // Counter stream delayed by 'shift' bits; words in [cor_lo, cor_lo+cor_n) are XORed with cor_mask.
    task automatic stream(input logic [7:0] start, input int n, input int shift, input int gap,
                          input logic [7:0] cor_lo, input int cor_n, input logic [7:0] cor_mask);
        logic [7:0]  c;
        logic [15:0] cat;
        logic [7:0]  d;
        for (int i = 0; i < n; i++) begin
            c   = start + 8'(i);
            cat = {c, last_c} << shift;
            d   = cat[15:8];
            if (8'(c - cor_lo) < 8'(cor_n)) d = d ^ cor_mask;
            last_c = c;
            drive(d, 1'b1);
            for (int g = 0; g < gap; g++) drive(8'h00, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0);
    endtask

    row_t rows[5];
    int   p0;

    initial begin
        rows[0] = '{rst: 1'b1, start: 8'h00, n: 17, shift: 0, gap: 0, exp_lk: 1'b0, exp_off: 3'd0};
        rows[1] = '{rst: 1'b0, start: 8'h11, n: 1,  shift: 0, gap: 0, exp_lk: 1'b1, exp_off: 3'd0};
        rows[2] = '{rst: 1'b1, start: 8'h00, n: 40, shift: 3, gap: 0, exp_lk: 1'b1, exp_off: 3'd3};
        rows[3] = '{rst: 1'b1, start: 8'hE8, n: 22, shift: 0, gap: 0, exp_lk: 1'b1, exp_off: 3'd0};
        rows[4] = '{rst: 1'b0, start: 8'hFE, n: 4,  shift: 0, gap: 5, exp_lk: 1'b1, exp_off: 3'd0};

        reset = 1'b1;
        din = '0;
        din_valid = 1'b0;
        model_reset();
        last_c = 8'hFF;
        @(negedge clk);

        for (int r = 0; r < 5; r++) begin
            if (rows[r].rst) do_reset(rows[r].start);
            p0 = err_pulses;
            stream(rows[r].start, rows[r].n, rows[r].shift, rows[r].gap, 8'h00, 0, 8'h00);
            idle(3);
            cmp("tbl_locked", 32'(locked), 32'(rows[r].exp_lk));
            cmp("tbl_offset", 32'(offset), 32'(rows[r].exp_off));
            cmp("tbl_no_error", 32'(err_pulses - p0), 32'd0);
        end

        // Single corrupted word while locked
        do_reset(8'h00);
        p0 = err_pulses;
        stream(8'h00, 8'h50, 0, 0, 8'h40, 1, 8'h01);
        idle(3);
        cmp("single_err_pulses", 32'(err_pulses - p0), 32'd1);
        cmp("single_locked", 32'(locked), 32'd1);
`ifdef RX_CHECKER_STATS_EN
        cmp("single_err_count", err_count, 32'd1);
`else
        cmp("single_err_count", err_count, 32'd0);
`endif

        // LOSS_THRESH consecutive corruptions drop lock, offset kept, then relock
        p0 = err_pulses;
        stream(8'h50, 5, 0, 0, 8'h50, 4, 8'h80);
        idle(3);
        cmp("loss_err_pulses", 32'(err_pulses - p0), 32'd4);
        cmp("loss_locked", 32'(locked), 32'd0);
        cmp("loss_offset", 32'(offset), 32'd0);
        stream(8'h55, 16, 0, 0, 8'h00, 0, 8'h00);
        idle(2);
        cmp("relock_early", 32'(locked), 32'd0);
        stream(8'h65, 1, 0, 0, 8'h00, 0, 8'h00);
        idle(2);
        cmp("relock", 32'(locked), 32'd1);

        // Reset while locked clears everything
        do_reset(8'h00);
        cmp("rst_locked", 32'(locked), 32'd0);
        cmp("rst_offset", 32'(offset), 32'd0);
        cmp("rst_err_count", err_count, 32'd0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rx_pattern_checker.md
# rx_pattern_checker

Receive-side link checker downstream of the LVDS DDR capture stage. Takes the 8-bit word assembled each `rxclk` cycle from the four IDDR lanes. Finds the bit offset at which the stream is an incrementing counter and locks to it. Then flags and counts mismatching words, giving link-quality status to the debug/ILA path and to IDELAY tap tuning.

## Interface
Parameters:
- `W`, 8: word width; must match the capture width.
- `LOCK_COUNT`, 16: consecutive good compares needed to declare lock; range 2..255.
- `LOSS_THRESH`, 4: consecutive bad compares in LOCKED that drop lock; range 1..255.
- `CNT_W`, 32: width of the statistics counters.

Ports:
- `clk`  in  1  capture clock (`rxclk` domain).
- `reset`  in  1  synchronous, active-high.
- `din`  in  W  captured word; bit 0 is the earliest-received bit.
- `din_valid`  in  1  `din` is valid this cycle; invalid cycles are ignored.
- `locked`  out  1  checker is in LOCKED.
- `error`  out  1  one-cycle pulse per mismatching word while LOCKED.
- `offset`  out  $clog2(W)  current alignment bit offset.
- `err_count`  out  CNT_W  saturating count of LOCKED mismatches.
- `word_count`  out  CNT_W  saturating count of words compared while LOCKED.

## Operation
- Stage 1, on each valid word:
  - `prev` <= `din`.
  - `aligned` <= ({din, prev} >> offset)[W-1:0].
  - `aligned` is marked valid only if `prev` was loaded since reset or since the last offset change.
- Stage 2 compares `aligned` against `expected`. All arithmetic is mod 2^W, so 8'hFF -> 8'h00 is a good compare.
- States:
  - HUNT (reset state): the first valid `aligned` after entry or after an offset change is a seed. It sets `expected` = `aligned`+1 and is not compared. After that:
    - Good compare: `good_cnt`++ and `expected` = `aligned`+1.
    - Bad compare: `good_cnt` = 0; `offset` = (offset+1) mod W; reseed.
    - When `good_cnt` reaches LOCK_COUNT: go to LOCKED.
  - LOCKED: `expected` increments on every valid compare, independent of the data, so one corrupted word gives exactly one error.
    - Good compare: `bad_run` = 0.
    - Bad compare: `error` pulse, `err_count`++, `bad_run`++.
    - When `bad_run` reaches LOSS_THRESH: go to HUNT with `offset` kept and reseed.
- `error` never asserts in HUNT.
- Counters saturate at all-ones. They clear only on `reset`, not on loss of lock.
- `reset` at any point: state HUNT, `offset` 0, all pipeline valids cleared.

## Timing
- Reset values: `locked` 0, `error` 0, `offset` 0, `err_count` 0, `word_count` 0.
- `error` is registered and asserts 2 cycles after the `din_valid` cycle carrying the bad word.
- `locked` rises 2 cycles after the valid cycle of the LOCK_COUNT-th good word. It falls 2 cycles after the LOSS_THRESH-th bad word.
- `offset` updates 2 cycles after the bad word. Stage 1 uses the new offset from the next valid word.
- `din_valid` low freezes all state; gaps of any length are allowed mid-stream.
- A bad compare in the same cycle as reaching LOSS_THRESH counts: `err_count` increments and `error` pulses on that cycle.

## Configuration
- `RX_CHECKER_STATS_EN` defined: `err_count` and `word_count` are implemented as described.
- Not defined: both are tied to 0 and the counter logic is removed. `locked`, `error` and `offset` behave identically in both builds.

## Structure
- Shared package `zmod_link_pkg`:
  - state enum `chk_state_t` {HUNT, LOCKED};
  - default `W`;
  - `sat_inc` function, also used by other link counters.
- One sub-module, `rx_word_aligner`: the `prev` register and barrel shift, with `offset` as input and `aligned`/`aligned_valid` as outputs. The FSM and counters stay in the top.

## Test plan
- Counter 0,1,2,… at offset 0, `din_valid` continuously 1 -> `locked` rises 2 cycles after the 16th good compare; `err_count` stays 0; `offset` = 0.
- Same stream delayed by 3 bits -> `offset` steps 0,1,2,3 and locks at 3. No `error` pulses during HUNT.
- Locked; word 8'h40 replaced by 8'h41 -> exactly one `error` pulse 2 cycles later, `err_count` = 1, `locked` stays 1.
- Locked; 4 consecutive corrupted words -> 4 `error` pulses, `locked` falls, `offset` unchanged; relock after 1 seed + 16 good compares.
- Wrap 8'hFE,8'hFF,8'h00,8'h01 with `din_valid` low 5 cycles between words -> no error, `word_count` += 4.
- `reset` high for 1 cycle while locked -> next cycle all outputs 0, state HUNT; with `RX_CHECKER_STATS_EN` undefined, counters read 0 throughout.
